// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from a zero-latency instruction memory and queues {pc, inst} for decode.
// Latency: a word fetched in cycle N is visible to decode in cycle N+1 (no bypass); redirect refills in 2 cycles.
// Backpressure: inst_valid/inst_ready handshake; fetch stalls only when full without a pop, so 1 instr/cycle is sustained.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   fetch_en            - allow new fetches (PC holds and FIFO drains when low)
//   pc_out / inst_in    - address to instruction memory / word returned in the same cycle
//   redirect_valid/_pc  - branch/jump from execute: flush the FIFO and reload the PC (word aligned)
//   inst_valid/_ready   - decode handshake; inst_out/inst_pc carry the head entry (0 when empty)
//   fifo_count          - current occupancy, 0..DEPTH
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [31:0]                pc_out,
  input  logic [31:0]                inst_in,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_out,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage carries no reset: every read is gated by a non-zero count.
  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] pc_mem_q   [DEPTH];

  logic empty;
  logic pop;
  logic push;

  assign empty = (count_q == '0);
  assign pop   = !empty && inst_ready;
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign push  = fetch_en && !redirect_valid && ((count_q < CW'(DEPTH)) || pop);

  assign pc_out     = fetch_pc_q;
  assign inst_valid = !empty;
  assign inst_out   = empty ? 32'h0 : inst_mem_q[rd_ptr_q];
  assign inst_pc    = empty ? 32'h0 : pc_mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // Redirect wins over everything; a same-cycle pop is dropped along with the flush.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= inst_in;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] pc_out;
  logic [31:0] inst_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [2:0]  fifo_count;

  // Second instance to exercise PC wrap-around from a high reset address.
  logic        w_reset;
  logic [31:0] w_pc_out;
  logic [31:0] w_inst_in;
  logic        w_inst_valid;
  logic [31:0] w_inst_out;
  logic [31:0] w_inst_pc;
  logic [2:0]  w_fifo_count;

  always #5 clk = ~clk;

  // Instruction memory: word at address A is A + 0x1000.
  assign inst_in   = pc_out + 32'h1000;
  assign w_inst_in = w_pc_out + 32'h1000;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_out(pc_out), .inst_in(inst_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc), .fifo_count(fifo_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .reset(w_reset), .fetch_en(1'b1), .pc_out(w_pc_out), .inst_in(w_inst_in),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .inst_valid(w_inst_valid),
    .inst_ready(1'b1), .inst_out(w_inst_out), .inst_pc(w_inst_pc), .fifo_count(w_fifo_count)
  );

  int asserts = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: a queue of fetched {pc, word} pairs and a fetch address.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;

  function automatic void model_reset(input logic [31:0] rpc);
    mq.delete();
    m_pc = rpc;
  endfunction

  function automatic void model_edge(input logic fe, input logic rv, input logic [31:0] rp, input logic rdy);
    int n = mq.size();
    bit pop_ok = (n != 0) && rdy;
    bit push_ok = fe && ((n < DEPTH) || pop_ok);
    ent_t e;
    if (rv) begin
      mq.delete();
      m_pc = rp & 32'hFFFF_FFFC;
    end else begin
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) begin
        e.pc = m_pc;
        e.inst = m_pc + 32'h1000;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] e_pc, e_inst;
    e_pc = 32'h0;
    e_inst = 32'h0;
    if (mq.size() != 0) begin
      e_pc = mq[0].pc;
      e_inst = mq[0].inst;
    end
    check({tag, ".pc_out"}, pc_out, m_pc);
    check({tag, ".inst_valid"}, {31'h0, inst_valid}, (mq.size() != 0) ? 32'h1 : 32'h0);
    check({tag, ".inst_pc"}, inst_pc, e_pc);
    check({tag, ".inst_out"}, inst_out, e_inst);
    check({tag, ".fifo_count"}, {29'h0, fifo_count}, 32'(mq.size()));
  endtask

  // Apply inputs for one clock edge, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic fe, input logic rv, input logic [31:0] rp, input logic rdy);
    fetch_en = fe;
    redirect_valid = rv;
    redirect_pc = rp;
    inst_ready = rdy;
    @(posedge clk);
    model_edge(fe, rv, rp, rdy);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset(32'h0);
  endtask

  typedef struct {
    logic        fe, rv, rdy;
    logic [31:0] rp;
    logic [31:0] e_pc, e_ipc, e_iout;
    logic        e_vld;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    w_reset = 1'b1;
    // fe rv rdy rp | pc_out ipc iout vld cnt (values after the edge)
    vecs[0]  = '{1, 0, 1, 32'h0,  32'h04, 32'h00, 32'h1000, 1, 1};
    vecs[1]  = '{1, 0, 1, 32'h0,  32'h08, 32'h04, 32'h1004, 1, 1};
    vecs[2]  = '{1, 0, 1, 32'h0,  32'h0C, 32'h08, 32'h1008, 1, 1};
    vecs[3]  = '{1, 0, 0, 32'h0,  32'h10, 32'h08, 32'h1008, 1, 2};
    vecs[4]  = '{1, 0, 0, 32'h0,  32'h14, 32'h08, 32'h1008, 1, 3};
    vecs[5]  = '{1, 0, 0, 32'h0,  32'h18, 32'h08, 32'h1008, 1, 4};
    vecs[6]  = '{1, 0, 0, 32'h0,  32'h18, 32'h08, 32'h1008, 1, 4};
    vecs[7]  = '{1, 1, 0, 32'h23, 32'h20, 32'h00, 32'h0000, 0, 0};
    vecs[8]  = '{1, 0, 0, 32'h0,  32'h24, 32'h20, 32'h1020, 1, 1};
    vecs[9]  = '{0, 0, 1, 32'h0,  32'h24, 32'h00, 32'h0000, 0, 0};
    vecs[10] = '{1, 1, 0, 32'h1F, 32'h1C, 32'h00, 32'h0000, 0, 0};
    vecs[11] = '{1, 0, 1, 32'h0,  32'h20, 32'h1C, 32'h101C, 1, 1};

    do_reset();
    check("rst.pc_out", pc_out, 32'h0);
    check("rst.inst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst.fifo_count", {29'h0, fifo_count}, 32'h0);
    check("rst.inst_out", inst_out, 32'h0);
    check("rst.inst_pc", inst_pc, 32'h0);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].fe, vecs[i].rv, vecs[i].rp, vecs[i].rdy);
      check($sformatf("vec%0d.pc_out", i), pc_out, vecs[i].e_pc);
      check($sformatf("vec%0d.inst_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].e_vld});
      check($sformatf("vec%0d.inst_pc", i), inst_pc, vecs[i].e_ipc);
      check($sformatf("vec%0d.inst_out", i), inst_out, vecs[i].e_iout);
      check($sformatf("vec%0d.fifo_count", i), {29'h0, fifo_count}, {29'h0, vecs[i].e_cnt});
    end

    // Saturation with decode stalled, then back-to-back drain.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 32'h0, 0);
      check($sformatf("sat%0d.fifo_count", i), {29'h0, fifo_count}, (i < 4) ? 32'(i + 1) : 32'd4);
      check($sformatf("sat%0d.inst_pc", i), inst_pc, 32'h0);
    end
    check("sat.pc_out", pc_out, 32'h10);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain%0d.inst_valid", k), {31'h0, inst_valid}, 32'h1);
      check($sformatf("drain%0d.inst_pc", k), inst_pc, 32'(k * 4));
      step(1, 0, 32'h0, 1);
    end

    // fetch_en low drains 3 queued entries while the PC holds, then resumes.
    step(1, 1, 32'h100, 0);
    repeat (3) step(1, 0, 32'h0, 0);
    check_model("fe0.pre");
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 32'h0, 1);
      check($sformatf("fe0_%0d.fifo_count", k), {29'h0, fifo_count}, 32'(2 - k));
      check($sformatf("fe0_%0d.pc_out", k), pc_out, 32'h10C);
    end
    step(1, 0, 32'h0, 1);
    check("fe0.resume.inst_pc", inst_pc, 32'h10C);
    check_model("fe0.resume");

    // Asynchronous reset between edges with 2 entries queued.
    step(1, 1, 32'h40, 0);
    repeat (2) step(1, 0, 32'h0, 0);
    check("arst.pre.fifo_count", {29'h0, fifo_count}, 32'h2);
    #3 reset = 1'b1;
    #1;
    check("arst.inst_valid", {31'h0, inst_valid}, 32'h0);
    check("arst.fifo_count", {29'h0, fifo_count}, 32'h0);
    check("arst.pc_out", pc_out, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset(32'h0);
    step(1, 0, 32'h0, 1);
    check_model("arst.resume");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), $urandom(), $urandom_range(0, 1) == 1);
      check_model($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d.count_le_depth", i), {31'h0, (fifo_count <= 3'(DEPTH))}, 32'h1);
    end

    // PC wrap from 0xFFFF_FFF8 on the second instance.
    @(negedge clk);
    w_reset = 1'b0;
    check("wrap.rst.pc_out", w_pc_out, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("wrap0.inst_pc", w_inst_pc, 32'hFFFF_FFF8);
    check("wrap0.inst_out", w_inst_out, 32'h0000_0FF8);
    @(posedge clk); #1;
    check("wrap1.inst_pc", w_inst_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap2.inst_pc", w_inst_pc, 32'h0000_0000);
    check("wrap2.inst_out", w_inst_out, 32'h0000_1000);
    check("wrap2.fifo_count", {29'h0, w_fifo_count}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch requester that drives the byte address into the combinational instruction memory and captures the returned 32-bit word. The block owns the program counter and buffers fetched words in a small FIFO. It presents {pc, instruction} pairs to decode over a valid/ready handshake. It sits between the instruction memory (upstream) and the decode stage (downstream) and accepts branch/jump redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset (must be 4-byte aligned)
DEPTH, 4, FIFO entries (power of two, 2..16)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
fetch_en  input  1  1 = fetch allowed; 0 = hold PC, no new pushes
pc_out  output  32  address to instruction memory (equals internal fetch_pc)
inst_in  input  32  word returned by instruction memory for pc_out, valid same cycle
redirect_valid  input  1  taken branch/jump; flush and refetch
redirect_pc  input  32  redirect target
inst_valid  output  1  head entry available to decode
inst_ready  input  1  decode accepts head entry this cycle
inst_out  output  32  head instruction
inst_pc  output  32  address of head instruction
fifo_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync-safe deassert): fetch_pc=RESET_PC, FIFO empty, fifo_count=0, inst_valid=0, inst_out=0, inst_pc=0.
- pc_out = fetch_pc, combinational from the register; inst_in is sampled in the same cycle (zero-latency memory).
- pop = inst_valid & inst_ready.
- push = fetch_en & !redirect_valid & (fifo_count<DEPTH | pop).
- On push: write {fetch_pc, inst_in} at the tail and set fetch_pc <= fetch_pc+4 (32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000).
- No push: fetch_pc holds.
- Full with a simultaneous pop: push is allowed, so occupancy stays at DEPTH and the pipeline sustains 1 instr/cycle.
- Empty with a push: the entry becomes visible the next cycle. Fetch-to-decode latency is 1 cycle; there is no bypass.
- inst_valid = (fifo_count!=0). inst_out and inst_pc are driven from the head entry and forced to 0 when empty.
- Redirect (highest priority):
  - fetch_pc <= {redirect_pc[31:2],2'b00}; the low 2 bits are silently cleared.
  - FIFO flushed: fifo_count <= 0, pointers reset.
  - No push that cycle; a pop in the same cycle is discarded, which is harmless because decode is squashed by the same redirect.
  - inst_valid=0 the following cycle. The first post-redirect entry appears 2 cycles after the redirect cycle if fetch_en=1 and the FIFO was not blocked.
- fetch_en=0: no pushes; pops continue and the FIFO drains; a redirect is still honoured (flush and PC load).
- fifo_count update: +1 on push only, -1 on pop only, unchanged on both or neither, 0 on redirect.
- Internal occupancy never exceeds DEPTH or underflows. The bench asserts: count<=DEPTH, and no pop while empty.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Test Plan:
- Reset, RESET_PC=0, fetch_en=1, inst_ready=1, memory word at addr A = A+0x1000 -> first cycle after reset pc_out=0. inst_valid rises one cycle later with inst_pc=0/inst_out=0x1000, then inst_pc=4,8,12... one per cycle.
- inst_ready=0 for 8 cycles after reset -> fifo_count climbs 1..4 and saturates. pc_out holds 0x10 while full. inst_pc stays 0. Releasing inst_ready gives 0,4,8,0xC,0x10 back-to-back with no bubble.
- FIFO full (pc_out=0x10), redirect_valid=1 with redirect_pc=0x23 -> next cycle fifo_count=0, inst_valid=0, pc_out=0x20. One cycle later inst_valid=1, inst_pc=0x20.
- fetch_en=0 with 3 entries queued and inst_ready=1 -> 3 pops, fifo_count 3->0, pc_out constant. Re-enabling resumes at the held address.
- RESET_PC=0xFFFF_FFF8, free-run -> inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Assert reset asynchronously between edges with 2 entries queued -> inst_valid=0, fifo_count=0, pc_out=RESET_PC immediately; normal fetch resumes after deassert.
